cpu_bus_ctrl: RTL and testbench
===============================

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 Parameter HALF_CYCLES, default 32, clk cycles per phi half-period (netlist settle time); values below 2 SHALL be an elaboration error.
REQ-002 Parameter RES_CYCLES, default 8, full phi cycles cpu_res is held low after res deasserts.
REQ-003 clk  in  1  FPGA clock; all state on posedge clk.
REQ-004 res  in  1  reset, asynchronous, active-low.
REQ-005 cpu_ab  in  16  CPU address bus; cpu_rw  in  1  (1=read); cpu_dbo  in  8  CPU write data; cpu_sync  in  1  opcode fetch.
REQ-006 phi  out  1  6502 clock; cpu_res  out  1  CPU reset, active-low; cpu_dbi  out  8  read data to CPU.
REQ-007 mem_req  out  1; mem_we  out  1; mem_addr  out  16; mem_wdata  out  8; mem_rdata  in  8; mem_ack  in  1  memory port.
REQ-008 trace_valid  out  1; trace_addr  out  16; trace_data  out  8; trace_rw  out  1; trace_sync  out  1  bus-cycle trace.

Function
REQ-009 FSM states S_PHI1 (phi=0), S_PHI2 (phi=1), S_STRETCH (phi=1, half-period expired, awaiting ack).
REQ-010 S_PHI1 SHALL last exactly HALF_CYCLES clk, then go to S_PHI2 with phi rising.
REQ-011 On the S_PHI1->S_PHI2 clk, cpu_ab and cpu_rw SHALL be captured into mem_addr and ~mem_we; cpu_sync captured for trace.
REQ-012 Read cycle: mem_req SHALL assert on the first S_PHI2 clk.
REQ-013 Write cycle: cpu_dbo SHALL be captured into mem_wdata and mem_req asserted on S_PHI2 count HALF_CYCLES-1.
REQ-014 mem_req SHALL stay high until mem_ack is sampled high, and SHALL drop the following clk; ack on the first req cycle is legal.
REQ-015 mem_ack sampled while mem_req is low SHALL be ignored.
REQ-016 On a read ack, cpu_dbi SHALL load mem_rdata next clk and hold until the next read ack.
REQ-017 After HALF_CYCLES clk in S_PHI2: ack received -> S_PHI1 (phi falls); else -> S_STRETCH.
REQ-018 S_STRETCH SHALL hold phi high indefinitely; the clk after ack -> S_PHI1.
REQ-019 Exactly one memory request per phi cycle.
REQ-020 cpu_res SHALL rise coincident with the RES_CYCLES-th phi falling edge after res deasserts; bus cycles run while cpu_res is low.
REQ-021 Phase counter width SHALL be $clog2(HALF_CYCLES)+1; no wrap before terminal count.

Reset
REQ-022 res low SHALL immediately force: S_PHI1, phi=0, cpu_res=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_dbi=8'h00, counters 0, trace outputs 0.
REQ-023 Reset mid-request SHALL drop mem_req without waiting for ack; a later stray ack is ignored per REQ-015.
REQ-024 First phi rise SHALL occur HALF_CYCLES clk after the first posedge with res high.

Configuration
REQ-025 Macro CPU_BUS_TRACE_EN defined: trace_valid pulses one clk on the clk phi falls, with trace_addr=mem_addr, trace_data=written or read byte, trace_rw=~mem_we, trace_sync=captured cpu_sync.
REQ-026 CPU_BUS_TRACE_EN undefined: trace ports present but tied to 0; no trace registers.

Structure
REQ-027 Package cpu_bus_pkg SHALL hold the state enum, default HALF_CYCLES/RES_CYCLES constants and the trace field widths.
REQ-028 Sub-module cpu_bus_phase SHALL implement the phase counter and terminal-count flag; cpu_bus_ctrl holds FSM, request and reset-sequencing logic.

Verification (HALF_CYCLES=4, RES_CYCLES=2)
REQ-029 Release res; ack every request immediately -> phi period 8 clk, 50% duty; cpu_res rises on 2nd phi fall.
REQ-030 Read cpu_ab=16'hFFFC, rw=1, mem_rdata=8'h34, ack 1 clk after req -> mem_addr=FFFC, mem_we=0, cpu_dbi=34 before phi falls.
REQ-031 Write cpu_ab=16'h0200, rw=0, cpu_dbo=8'hA5 -> mem_req on phi2 count 3, mem_we=1, mem_wdata=A5; trace_valid pulse with addr 0200, data A5.
REQ-032 Ack delayed 10 clk past req -> phi high for 4+stretch clk, falls the clk after ack, single request only.
REQ-033 Assert res while mem_req high -> mem_req, phi, cpu_res low same cycle; stray ack next clk causes no request and no cpu_dbi change.
REQ-034 Build without CPU_BUS_TRACE_EN, run REQ-031 -> trace outputs constant 0, memory behaviour identical.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and defaults for the 6502 bus controller.
// Optional trace capture is enabled by defining CPU_BUS_TRACE_EN.
package cpu_bus_pkg;

    // Encoding keeps phi == state[0] so phi comes straight off one flop.
    typedef enum logic [1:0] {
        S_PHI1    = 2'b00,
        S_PHI2    = 2'b01,
        S_STRETCH = 2'b11
    } state_e;

    localparam int DEF_HALF_CYCLES = 32;
    localparam int DEF_RES_CYCLES  = 8;

    localparam int TRACE_AW = 16;
    localparam int TRACE_DW = 8;

endpackage

// File: rtl/cpu_bus_phase.sv
// Phase counter: counts clk within one phi half-period and flags the
// terminal count. Saturates at terminal count so a stretched phase never wraps.
module cpu_bus_phase
    import cpu_bus_pkg::*;
#(
    parameter  int HALF_CYCLES = DEF_HALF_CYCLES,
    localparam int CW          = $clog2(HALF_CYCLES) + 1
)(
    input  logic          clk,
    input  logic          res,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    if (HALF_CYCLES < 2) begin : g_bad_half
        $error("cpu_bus_phase: HALF_CYCLES must be at least 2");
    end

    localparam logic [CW-1:0] TC = CW'(HALF_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: restart on phase change, otherwise climb to terminal count and hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (cnt_q != TC)
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/cpu_bus_ctrl.sv
// 6502 bus controller: generates phi, sequences cpu_res, turns each phi
// cycle into exactly one memory request and stretches phi2 until ack.
// Define CPU_BUS_TRACE_EN to get a one-clk trace record per bus cycle.
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int HALF_CYCLES = DEF_HALF_CYCLES,
    parameter int RES_CYCLES  = DEF_RES_CYCLES
)(
    input  logic                clk,
    input  logic                res,
    input  logic [15:0]         cpu_ab,
    input  logic                cpu_rw,
    input  logic [7:0]          cpu_dbo,
    input  logic                cpu_sync,
    output logic                phi,
    output logic                cpu_res,
    output logic [7:0]          cpu_dbi,
    output logic                mem_req,
    output logic                mem_we,
    output logic [15:0]         mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic [7:0]          mem_rdata,
    input  logic                mem_ack,
    output logic                trace_valid,
    output logic [TRACE_AW-1:0] trace_addr,
    output logic [TRACE_DW-1:0] trace_data,
    output logic                trace_rw,
    output logic                trace_sync
);

    localparam int CW = $clog2(HALF_CYCLES) + 1;
    localparam int RW = $clog2(RES_CYCLES + 1);
    localparam logic [CW-1:0] WR_ISSUE = CW'(HALF_CYCLES - 2);
    localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt;
    logic          tc, phase_clr, rise, fall, ack_hit, wr_go;
    logic          ack_done_q, ack_done_d;
    logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d, cpu_dbi_q, cpu_dbi_d;
    logic          cpu_res_q, cpu_res_d;
    logic [RW-1:0] res_cnt_q, res_cnt_d;

    cpu_bus_phase #(.HALF_CYCLES(HALF_CYCLES)) u_phase (
        .clk   (clk),
        .res   (res),
        .clr_i (phase_clr),
        .cnt_o (cnt),
        .tc_o  (tc)
    );

    // An ack only counts while a request is outstanding; stray acks are dropped.
    assign ack_hit = mem_req_q & mem_ack;

    // Next state: fixed phi1, fixed phi2, then stretch phi2 until the ack lands.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PHI1:    if (tc) state_d = S_PHI2;
            S_PHI2:    if (tc) state_d = (ack_done_q || ack_hit) ? S_PHI1 : S_STRETCH;
            S_STRETCH: if (ack_hit) state_d = S_PHI1;
            default:   state_d = S_PHI1;
        endcase
    end

    assign rise      = (state_q == S_PHI1) && (state_d == S_PHI2);
    assign fall      = (state_q != S_PHI1) && (state_d == S_PHI1);
    assign phase_clr = rise | fall;
    // Writes launch late in phi2 so the CPU's write data has settled.
    assign wr_go     = (state_q == S_PHI2) && (cnt == WR_ISSUE) && mem_we_q;

    // Next request/datapath/reset-sequencer values.
    always_comb begin
        ack_done_d  = ack_done_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_dbi_d   = cpu_dbi_q;
        cpu_res_d   = cpu_res_q;
        res_cnt_d   = res_cnt_q;

        if (ack_hit) begin
            mem_req_d  = 1'b0;
            ack_done_d = 1'b1;
            if (!mem_we_q) cpu_dbi_d = mem_rdata;
        end
        if (rise) begin
            mem_addr_d = cpu_ab;
            mem_we_d   = ~cpu_rw;
            ack_done_d = 1'b0;
            if (cpu_rw) mem_req_d = 1'b1;
        end
        if (wr_go) begin
            mem_wdata_d = cpu_dbo;
            mem_req_d   = 1'b1;
        end
        if (fall && !cpu_res_q) begin
            if (res_cnt_q == RES_LAST) cpu_res_d = 1'b1;
            else                       res_cnt_d = res_cnt_q + RW'(1);
        end
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= S_PHI1;
            ack_done_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_dbi_q   <= 8'h00;
            cpu_res_q   <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ack_done_q  <= ack_done_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_dbi_q   <= cpu_dbi_d;
            cpu_res_q   <= cpu_res_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign phi       = state_q[0];
    assign cpu_res   = cpu_res_q;
    assign cpu_dbi   = cpu_dbi_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef CPU_BUS_TRACE_EN
    logic                sync_q, trace_valid_q, trace_rw_q, trace_sync_q;
    logic [TRACE_AW-1:0] trace_addr_q;
    logic [TRACE_DW-1:0] trace_data_q, rd_byte;

    // A read acked on the final phi2 clk has not reached cpu_dbi yet.
    assign rd_byte = ack_hit ? mem_rdata : cpu_dbi_q;

    // Record the finished bus cycle on the clk phi falls.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync_q        <= 1'b0;
            trace_valid_q <= 1'b0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
            trace_rw_q    <= 1'b0;
            trace_sync_q  <= 1'b0;
        end else begin
            trace_valid_q <= fall;
            if (rise) sync_q <= cpu_sync;
            if (fall) begin
                trace_addr_q <= mem_addr_q;
                trace_data_q <= mem_we_q ? mem_wdata_q : rd_byte;
                trace_rw_q   <= ~mem_we_q;
                trace_sync_q <= sync_q;
            end
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;
    assign trace_rw    = trace_rw_q;
    assign trace_sync  = trace_sync_q;
`else
    logic unused_sync;
    assign unused_sync = cpu_sync;

    assign trace_valid = 1'b0;
    assign trace_addr  = '0;
    assign trace_data  = '0;
    assign trace_rw    = 1'b0;
    assign trace_sync  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Scoreboard bench for cpu_bus_ctrl with HALF_CYCLES=4, RES_CYCLES=2.
module tb_cpu_bus_ctrl;
    import cpu_bus_pkg::*;

    localparam int HALF = 4;
    localparam int RESC = 2;
`ifdef CPU_BUS_TRACE_EN
    localparam bit TRC = 1'b1;
`else
    localparam bit TRC = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                res;
    logic [15:0]         cpu_ab;
    logic                cpu_rw;
    logic [7:0]          cpu_dbo;
    logic                cpu_sync;
    logic                phi, cpu_res, mem_req, mem_we, mem_ack;
    logic [7:0]          cpu_dbi, mem_wdata, mem_rdata;
    logic [15:0]         mem_addr;
    logic                trace_valid, trace_rw, trace_sync;
    logic [TRACE_AW-1:0] trace_addr;
    logic [TRACE_DW-1:0] trace_data;

    always #5 clk = ~clk;

    cpu_bus_ctrl #(.HALF_CYCLES(HALF), .RES_CYCLES(RESC)) dut (
        .clk(clk), .res(res),
        .cpu_ab(cpu_ab), .cpu_rw(cpu_rw), .cpu_dbo(cpu_dbo), .cpu_sync(cpu_sync),
        .phi(phi), .cpu_res(cpu_res), .cpu_dbi(cpu_dbi),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_rw(trace_rw), .trace_sync(trace_sync)
    );

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic        sync;
    } txn_t;

    txn_t       exp_q[$];
    txn_t       cur;
    int         checks = 0;
    int         fails  = 0;
    int         lo_idx;
    int         falls;
    logic [7:0] exp_dbi;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one CPU bus cycle during phi1, wait for phi2 and the request.
    task automatic start_cycle(input logic [15:0] a, input logic rw, input logic [7:0] dbo,
                               input logic [7:0] rd, input logic sy, output int r, output bit ok);
        txn_t t;
        int   n;
        ok = 1'b0;
        r  = 0;
        cpu_ab = a; cpu_rw = rw; cpu_dbo = dbo; cpu_sync = sy;
        t.addr = a; t.we = !rw; t.wdata = dbo; t.rdata = rd; t.sync = sy;
        exp_q.push_back(t);
        n = lo_idx;
        while (!phi && n < 100) begin tick(); n++; end
        chk("phi_low_clks", n, HALF);
        if (!phi) begin exp_q.delete(); return; end
        while (!mem_req && r < 2 * HALF) begin tick(); r++; end
        chk("req_offset", r, rw ? 0 : HALF - 1);
        if (!mem_req) begin exp_q.delete(); return; end
        cur = exp_q.pop_front();
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", mem_we, cur.we);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
        ok = 1'b1;
    endtask

    // Ack after d clk, then check phi timing, read data, reset sequencing and trace.
    task automatic finish_cycle(input int r, input int d);
        int hi, extra, exp_hi;
        bit held;
        held = 1'b1;
        for (int i = 0; i < d; i++) begin
            if (!mem_req) held = 1'b0;
            tick();
        end
        chk("req_held_until_ack", held, 1);
        mem_ack = 1'b1; mem_rdata = cur.rdata;
        tick();
        mem_ack = 1'b0; mem_rdata = 8'hEE;
        chk("req_drop_after_ack", mem_req, 0);
        hi = r + d + 1; extra = 0;
        while (phi && hi < 200) begin
            if (mem_req) extra++;
            tick(); hi++;
        end
        exp_hi = (r + d + 1 > HALF) ? r + d + 1 : HALF;
        chk("phi_high_clks", hi, exp_hi);
        chk("single_req", extra, 0);
        if (!cur.we) exp_dbi = cur.rdata;
        chk("cpu_dbi", cpu_dbi, exp_dbi);
        falls++;
        chk("cpu_res", cpu_res, falls >= RESC);
        chk("trace_valid", trace_valid, TRC);
        chk("trace_addr", trace_addr, TRC ? cur.addr : 16'h0);
        chk("trace_data", trace_data, TRC ? (cur.we ? cur.wdata : cur.rdata) : 8'h0);
        chk("trace_rw", trace_rw, TRC ? !cur.we : 1'b0);
        chk("trace_sync", trace_sync, TRC ? cur.sync : 1'b0);
        tick();
        chk("trace_pulse_end", trace_valid, 0);
        lo_idx = 1;
    endtask

    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] dbo,
                             input logic [7:0] rd, input logic sy, input int d);
        int r;
        bit ok;
        start_cycle(a, rw, dbo, rd, sy, r, ok);
        if (ok) finish_cycle(r, d);
    endtask

    initial begin
        int r;
        bit ok;
        res = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
        cpu_ab = '0; cpu_rw = 1'b1; cpu_dbo = '0; cpu_sync = 1'b0;
        #2 res = 1'b0;
        repeat (3) tick();
        chk("rst_phi", phi, 0);
        chk("rst_cpu_res", cpu_res, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_cpu_dbi", cpu_dbi, 0);
        chk("rst_trace", {trace_valid, trace_addr, trace_data, trace_rw, trace_sync}, 0);

        res = 1'b1; lo_idx = 0; falls = 0; exp_dbi = 8'h00;
        bus_cycle(16'h1000, 1'b1, 8'h00, 8'h11, 1'b1, 0);
        bus_cycle(16'h1001, 1'b1, 8'h00, 8'h22, 1'b0, 0);
        bus_cycle(16'hFFFC, 1'b1, 8'h00, 8'h34, 1'b1, 1);
        bus_cycle(16'h0200, 1'b0, 8'hA5, 8'h00, 1'b0, 0);
        bus_cycle(16'h3000, 1'b1, 8'h00, 8'h5A, 1'b0, 10);
        bus_cycle(16'h0201, 1'b0, 8'h3C, 8'h00, 1'b0, 2);
        for (int i = 0; i < 8; i++)
            bus_cycle(16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                      8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 5));

        // Reset while a request is outstanding, then a stray ack after release.
        start_cycle(16'h4000, 1'b1, 8'h00, 8'h77, 1'b0, r, ok);
        if (ok) begin
            res = 1'b0;
            #1;
            chk("midrst_mem_req", mem_req, 0);
            chk("midrst_phi", phi, 0);
            chk("midrst_cpu_res", cpu_res, 0);
            tick(); tick();
            res = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hFF;
            tick();
            mem_ack = 1'b0;
            chk("stray_ack_req", mem_req, 0);
            chk("stray_ack_dbi", cpu_dbi, 8'h00);
            chk("stray_ack_addr", mem_addr, 0);
            exp_dbi = 8'h00; lo_idx = 1; falls = 0;
            bus_cycle(16'h5000, 1'b1, 8'h00, 8'h99, 1'b1, 0);
            bus_cycle(16'h5001, 1'b0, 8'h66, 8'h00, 1'b0, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
